// File: rtl/lab1_g29_sweep.sv
// Purpose : exhaustive stimulus sequencer/recorder wrapped around the lab1_g29_p2 block.
// Latency : each of the 16 vectors is held DWELL_CYCLES cycles; done rises 16*DWELL_CYCLES cycles after start.
// Backpr. : none; start is ignored while busy, abort returns to IDLE on the next edge.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, abort      sweep control (abort wins over start and over a same-edge sample)
//   y                 response from the combinational block under test
//   g, t, u, e        vector drive {g,t,u,e} == vec_idx while busy, 0 otherwise
//   vec_idx           current vector index
//   busy, done        state flags for APPLY and DONE
//   result            captured truth vector, bit i = y sampled for vector i
//   mismatch, first_err_idx (only with LAB1_SWEEP_CHECK_EN defined)
//                     sticky compare against EXPECTED and the first failing index
//
// Optional feature macro: LAB1_SWEEP_CHECK_EN
module lab1_g29_sweep #(
  parameter int          DWELL_CYCLES = 10,
  parameter logic [15:0] EXPECTED     = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        y,
  output logic        g,
  output logic        t,
  output logic        u,
  output logic        e,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
`ifdef LAB1_SWEEP_CHECK_EN
  output logic        mismatch,
  output logic [3:0]  first_err_idx,
`endif
  output logic [15:0] result
);

  // Dwell counter only has to reach DWELL_CYCLES-1; never narrower than 1 bit.
  localparam int DW_RAW = $clog2(DWELL_CYCLES + 1);
  localparam int DW     = (DW_RAW < 1) ? 1 : DW_RAW;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] dwell;
  logic          start_acc;   // start accepted this edge (IDLE/DONE, no abort)
  logic          sample;      // end of dwell: capture y and advance
  logic          abort_run;   // abort while a sweep is in progress

  // Next-state decode. abort has priority everywhere, including over a
  // sample falling on the same edge, so a partial result never gains a bit
  // from the vector that was being aborted.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    sample    = 1'b0;
    abort_run = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = APPLY;
          start_acc = 1'b1;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
          abort_run = 1'b1;
        end else if (dwell == DWELL_LAST) begin
          sample = 1'b1;
          if (vec_idx == 4'd15) begin
            state_nxt = DONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sweep datapath: vector index, dwell counter and captured truth vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_idx <= 4'd0;
      dwell   <= '0;
      result  <= 16'h0000;
    end else if (start_acc) begin
      vec_idx <= 4'd0;
      dwell   <= '0;
      result  <= 16'h0000;
    end else if (abort_run) begin
      // result keeps its partial content for inspection
      vec_idx <= 4'd0;
      dwell   <= '0;
    end else if (sample) begin
      result[vec_idx] <= y;
      dwell           <= '0;
      vec_idx         <= vec_idx + 4'd1;  // 15 wraps to 0 on entry to DONE
    end else if (state == APPLY) begin
      dwell <= dwell + 1'b1;
    end
  end

`ifdef LAB1_SWEEP_CHECK_EN
  // Sticky compare: only the first disagreement is recorded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch      <= 1'b0;
      first_err_idx <= 4'd0;
    end else if (start_acc) begin
      mismatch      <= 1'b0;
      first_err_idx <= 4'd0;
    end else if (sample && !mismatch && (y != EXPECTED[vec_idx])) begin
      mismatch      <= 1'b1;
      first_err_idx <= vec_idx;
    end
  end
`endif

  // Outputs are decoded from state so an asynchronous reset forces them low
  // immediately, without waiting for an edge.
  always_comb begin
    g    = 1'b0;
    t    = 1'b0;
    u    = 1'b0;
    e    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      APPLY: begin
        {g, t, u, e} = vec_idx;
        busy         = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/lab1_g29_sweep.md
Name: lab1_g29_sweep

Overview:
- Stimulus sequencer and response recorder that sits directly upstream of, and wraps around, the lab1_g29_p2 combinational block.
- Drives G,T,U,E through all 16 combinations in ascending order and holds each vector for a programmable dwell.
- Samples the block's y output at the end of each dwell and assembles a 16-bit truth-table vector for the board LEDs/checker.
- Replaces hand-written exhaustive stimulus with synthesizable hardware usable on the lab FPGA.

Parameters:
- DWELL_CYCLES, 10, clock cycles each input vector is held (legal range 1..65535).
- EXPECTED, 16'h0000, golden truth vector; bit i = expected y for vector i. Used only with the optional feature.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- abort  input  1  stops a sweep in progress; returns to IDLE.
- y  input  1  response from lab1_g29_p2.
- g  output  1  drive to G (vector bit 3).
- t  output  1  drive to T (vector bit 2).
- u  output  1  drive to U (vector bit 1).
- e  output  1  drive to E (vector bit 0).
- vec_idx  output  4  current vector index; {g,t,u,e} == vec_idx while busy.
- busy  output  1  high in APPLY.
- done  output  1  high in DONE.
- result  output  16  captured truth vector; bit i = y sampled for vector i.

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: state IDLE; g=t=u=e=0; vec_idx=0; busy=0; done=0; result=16'h0000; dwell counter=0.
- Reset asserted mid-sweep clears everything immediately, without waiting for a clock edge.
- States: IDLE, APPLY, DONE.
- IDLE:
  - Outputs g,t,u,e are 0.
  - start=1 at a rising edge moves to APPLY next cycle with vec_idx=0, dwell=0, result cleared to 0.
- APPLY:
  - {g,t,u,e} = vec_idx. busy=1.
  - The dwell counter increments every cycle.
  - On the edge where dwell==DWELL_CYCLES-1: result[vec_idx] <= y, dwell <= 0, then:
    - vec_idx<15: vec_idx <= vec_idx+1.
    - vec_idx==15: go to DONE; vec_idx wraps to 0.
  - Each vector is held exactly DWELL_CYCLES cycles. Total busy time is 16*DWELL_CYCLES cycles.
  - With DWELL_CYCLES=1, the vector advances every cycle and y is sampled in the same cycle the vector is presented. The downstream block is purely combinational, so this is legal.
  - start is ignored in APPLY.
  - abort=1 goes to IDLE next cycle and drives the outputs to 0. result holds its partial content and done stays 0.
  - abort takes priority over a sample on the same edge; that sample is discarded.
- DONE:
  - done=1, busy=0, g=t=u=e=0. result is stable until the next start.
  - start=1 restarts the sweep as from IDLE, and done drops on that edge.
  - abort in DONE returns to IDLE; done clears and result is kept.
- start and abort asserted together in IDLE/DONE: abort wins and the state stays or becomes IDLE.
- Dwell counter width is $clog2(DWELL_CYCLES+1), minimum 1 bit.

Optional Feature:
- Macro: LAB1_SWEEP_CHECK_EN.
- Defined:
  - Adds output mismatch (1 bit, reset 0) and output first_err_idx (4 bits, reset 0).
  - On each sample, if y != EXPECTED[vec_idx] and mismatch is 0: mismatch <= 1 and first_err_idx <= vec_idx.
  - Both clear on an accepted start.
  - mismatch is meaningful once done=1.
- Undefined: neither port exists and no compare logic is built.

Test Plan:
- Reset asserted mid-APPLY at vec_idx=5, between clock edges -> all outputs 0 and state IDLE immediately; after deassert, no activity until start.
- DUT y=(G&T)|(U&E), DWELL_CYCLES=10, start pulse -> {g,t,u,e} steps 0..15, each held 10 cycles; busy high 160 cycles; then done=1 and result=16'hF888.
- DWELL_CYCLES=1, same DUT -> done after 16 busy cycles; result=16'hF888; start pulsed during busy has no effect.
- abort at vec_idx=7 during dwell -> IDLE next cycle; done=0; result bits 0..6 hold captured values and bits 7..15 are 0; a new start gives a full correct sweep.
- From DONE, start again with the DUT changed to y=G^E -> result=16'h55AA, and done re-asserts after 16*DWELL_CYCLES cycles.
- LAB1_SWEEP_CHECK_EN, EXPECTED=16'hF888, DUT forced with y wrong at vector 11 only -> mismatch=1, first_err_idx=11, result=16'hF088; with the correct DUT, mismatch=0.
